// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file. State updates on the falling clock edge.
// A clear sequencer zeroes the array after reset or on request, then raises ready.

module reg_file_rd_port #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int REG_COUNT     = 32,
  parameter bit ZERO_REG      = 1'b1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     ready,
  input  logic                     en,
  input  logic [REG_IDX_WIDTH-1:0] idx,
  input  logic                     wr_ok,
  input  logic [REG_IDX_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic [DATA_WIDTH-1:0]    data
);
  localparam logic [REG_IDX_WIDTH:0] RC_W = (REG_IDX_WIDTH+1)'(REG_COUNT);

  logic idx_ok;
  assign idx_ok = ({1'b0, idx} < RC_W) && !(ZERO_REG && (idx == '0));

  always_ff @(negedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)                   data <= '0;
    else if (!ready || !en || !idx_ok) data <= '0;
    else if (wr_ok && wr_idx == idx) data <= wr_data;
    else                            data <= mem_data;
  end
endmodule

module reg_file_2r1w #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int REG_COUNT     = 32,
  parameter bit ZERO_REG      = 1'b1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     clr,
  output logic                     ready,
  input  logic                     rd_en_a,
  input  logic [REG_IDX_WIDTH-1:0] rd_idx_a,
  output logic [DATA_WIDTH-1:0]    rd_data_a,
  input  logic                     rd_en_b,
  input  logic [REG_IDX_WIDTH-1:0] rd_idx_b,
  output logic [DATA_WIDTH-1:0]    rd_data_b,
  input  logic                     wr_en,
  input  logic [REG_IDX_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]    wr_data
);
  localparam int NUM_RD = 2;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [REG_IDX_WIDTH:0] RC_W     = (REG_IDX_WIDTH+1)'(REG_COUNT);
  localparam logic [REG_IDX_WIDTH:0] CNT_LAST = (REG_IDX_WIDTH+1)'(REG_COUNT-1);
  localparam logic [REG_IDX_WIDTH:0] CNT_ONE  = (REG_IDX_WIDTH+1)'(1);

  logic [0:0]               state;
  logic [REG_IDX_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0]    mem [REG_COUNT];
  logic                     wr_ok;

  logic [NUM_RD-1:0]                    rd_en;
  logic [NUM_RD-1:0][REG_IDX_WIDTH-1:0] rd_idx;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]    mem_rd;

  assign ready = (state == ST_READY);

  // clr on the same edge drops the write; suppressed writes also kill the bypass
  assign wr_ok = ready && !clr && wr_en && ({1'b0, wr_idx} < RC_W)
                 && !(ZERO_REG && (wr_idx == '0));

  always_ff @(negedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (clr) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        state <= ST_READY;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // array has no reset; the sweep is what clears it
  always_ff @(negedge sys_clk) begin
    if (state == ST_CLEAR && !clr) mem[cnt[REG_IDX_WIDTH-1:0]] <= '0;
    else if (wr_ok)                mem[wr_idx] <= wr_data;
  end

  assign rd_en  = {rd_en_b, rd_en_a};
  assign rd_idx = {rd_idx_b, rd_idx_a};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign mem_rd[p] = mem[rd_idx[p]];
    reg_file_rd_port #(
      .DATA_WIDTH(DATA_WIDTH), .REG_IDX_WIDTH(REG_IDX_WIDTH),
      .REG_COUNT(REG_COUNT), .ZERO_REG(ZERO_REG)
    ) u_port (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .ready(ready),
      .en(rd_en[p]), .idx(rd_idx[p]),
      .wr_ok(wr_ok), .wr_idx(wr_idx), .wr_data(wr_data),
      .mem_data(mem_rd[p]), .data(rd_data[p])
    );
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: one instance with ZERO_REG=1, one with ZERO_REG=0,
// sharing stimulus and checked against an array-based reference model.
module tb_reg_file_2r1w;
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        clr = 1'b0, wr_en = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic [4:0]  rd_idx_a = '0, rd_idx_b = '0, wr_idx = '0;
  logic [31:0] wr_data = '0;
  logic        ready, ready0;
  logic [31:0] rd_data_a, rd_data_b, rd_data_a0, rd_data_b0;

  int checks = 0, errors = 0;

  reg_file_2r1w #(.ZERO_REG(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .ready(ready),
    .rd_en_a(rd_en_a), .rd_idx_a(rd_idx_a), .rd_data_a(rd_data_a),
    .rd_en_b(rd_en_b), .rd_idx_b(rd_idx_b), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data));

  reg_file_2r1w #(.ZERO_REG(1'b0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .ready(ready0),
    .rd_en_a(rd_en_a), .rd_idx_a(rd_idx_a), .rd_data_a(rd_data_a0),
    .rd_en_b(rd_en_b), .rd_idx_b(rd_idx_b), .rd_data_b(rd_data_b0),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data));

  always #5 sys_clk = ~sys_clk;

  // reference model: register contents plus number of sweep edges still owed
  logic [31:0] mem1 [32];
  logic [31:0] mem0 [32];
  bit          m_ready;
  int          left;
  logic [31:0] e_a1, e_b1, e_a0, e_b0;

  function automatic logic [31:0] mrd(bit z, logic en, logic [4:0] idx);
    if (!en) return 32'h0;
    if (z && idx == 5'd0) return 32'h0;
    if (wr_en && !clr && !(z && wr_idx == 5'd0) && wr_idx == idx) return wr_data;
    return z ? mem1[idx] : mem0[idx];
  endfunction

  task automatic model_reset();
    m_ready = 1'b0; left = 32;
    e_a1 = '0; e_b1 = '0; e_a0 = '0; e_b0 = '0;
  endtask

  task automatic model_edge();
    if (!m_ready) begin
      e_a1 = '0; e_b1 = '0; e_a0 = '0; e_b0 = '0;
      if (clr) left = 32;
      else begin
        left--;
        if (left == 0) begin
          m_ready = 1'b1;
          for (int i = 0; i < 32; i++) begin mem1[i] = '0; mem0[i] = '0; end
        end
      end
    end else begin
      e_a1 = mrd(1'b1, rd_en_a, rd_idx_a); e_b1 = mrd(1'b1, rd_en_b, rd_idx_b);
      e_a0 = mrd(1'b0, rd_en_a, rd_idx_a); e_b0 = mrd(1'b0, rd_en_b, rd_idx_b);
      if (clr) begin m_ready = 1'b0; left = 32; end
      else if (wr_en) begin
        if (wr_idx != 5'd0) mem1[wr_idx] = wr_data;
        mem0[wr_idx] = wr_data;
      end
    end
  endtask

  task automatic cycle();
    @(negedge sys_clk);
    if (sys_rst) model_edge();
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; #1; sys_rst = 1'b0; model_reset(); #1;
    checks++;
    if ({ready, ready0, rd_data_a, rd_data_b, rd_data_a0, rd_data_b0} !== '0) begin
      errors++; $display("FAIL reset_state: ready=%b data_a=%h data_b=%h, required all 0", ready, rd_data_a, rd_data_b);
    end
    cycle(); cycle();
    sys_rst = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      cycle();
      checks++;
      if (ready !== (i == 32) || ready0 !== (i == 32)) begin
        errors++; $display("FAIL reset_sweep edge %0d: ready=%b/%b, required %b", i, ready, ready0, i == 32);
      end
    end
    for (int i = 0; i < 32; i++) begin
      rd_en_a = 1'b1; rd_idx_a = 5'(i); rd_en_b = 1'b1; rd_idx_b = 5'(31 - i);
      cycle();
      checks++;
      if ({rd_data_a, rd_data_b, rd_data_a0, rd_data_b0} !== '0) begin
        errors++; $display("FAIL reset_cleared x%0d: a=%h b=%h a0=%h b0=%h, required 0", i, rd_data_a, rd_data_b, rd_data_a0, rd_data_b0);
      end
    end
    idle();
  endtask

  task automatic test_dual_read();
    wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'h1234_5678; cycle();
    wr_idx = 5'd9; wr_data = 32'hDEAD_BEEF; cycle();
    wr_en = 1'b0; rd_en_a = 1'b1; rd_idx_a = 5'd5; rd_en_b = 1'b1; rd_idx_b = 5'd9; cycle();
    checks++;
    if (rd_data_a !== 32'h1234_5678 || rd_data_b !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL dual_read: a=%h b=%h, required 12345678 deadbeef", rd_data_a, rd_data_b);
    end
    rd_idx_a = 5'd9; rd_idx_b = 5'd9; cycle();
    checks++;
    if (rd_data_a !== 32'hDEAD_BEEF || rd_data_b !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL dual_same_idx: a=%h b=%h, required deadbeef", rd_data_a, rd_data_b);
    end
    idle();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_idx = 5'd7; wr_data = 32'h11; cycle();
    wr_data = 32'h22; rd_en_a = 1'b1; rd_idx_a = 5'd7; rd_en_b = 1'b0; rd_idx_b = 5'd7; cycle();
    checks++;
    if (rd_data_a !== 32'h22 || rd_data_a0 !== 32'h22 || rd_data_b !== 32'h0) begin
      errors++; $display("FAIL bypass: a=%h a0=%h b=%h, required 22 22 0", rd_data_a, rd_data_a0, rd_data_b);
    end
    wr_en = 1'b0; cycle();
    checks++;
    if (rd_data_a !== 32'h22) begin
      errors++; $display("FAIL bypass_readback: a=%h, required 22", rd_data_a);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_idx = 5'd0; wr_data = 32'hFFFF_FFFF;
    rd_en_a = 1'b1; rd_idx_a = 5'd0; rd_en_b = 1'b1; rd_idx_b = 5'd0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (rd_data_a !== '0 || rd_data_b !== '0 || rd_data_a0 !== 32'hFFFF_FFFF || rd_data_b0 !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL zero_reg pass %0d: a=%h b=%h a0=%h b0=%h, required 0 0 ffffffff ffffffff", k, rd_data_a, rd_data_b, rd_data_a0, rd_data_b0);
      end
      wr_en = 1'b0;
    end
    idle();
  endtask

  task automatic test_clear();
    wr_en = 1'b1; wr_idx = 5'd3; wr_data = 32'hABCD; cycle();
    clr = 1'b1; wr_idx = 5'd4; wr_data = 32'h55; cycle();
    clr = 1'b0; wr_en = 1'b0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL clear_drop_ready: ready=%b, required 0", ready); end
    for (int i = 1; i <= 32; i++) begin
      cycle();
      checks++;
      if (ready !== (i == 32)) begin
        errors++; $display("FAIL clear_sweep edge %0d: ready=%b, required %b", i, ready, i == 32);
      end
    end
    rd_en_a = 1'b1; rd_idx_a = 5'd3; rd_en_b = 1'b1; rd_idx_b = 5'd4; cycle();
    checks++;
    if (rd_data_a !== '0 || rd_data_b !== '0 || rd_data_b0 !== '0) begin
      errors++; $display("FAIL clear_contents: x3=%h x4=%h, required 0 0", rd_data_a, rd_data_b);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    wr_en = 1'b1; wr_idx = 5'd12; wr_data = $urandom | 32'h1; cycle();
    wr_en = 1'b0; rd_en_a = 1'b1; rd_idx_a = 5'd12; rd_en_b = 1'b1; rd_idx_b = 5'd12; cycle();
    #2 sys_rst = 1'b0; model_reset(); #1;
    checks++;
    if ({ready, rd_data_a, rd_data_b, rd_data_a0, rd_data_b0} !== '0) begin
      errors++; $display("FAIL async_reset: ready=%b a=%h b=%h, required 0", ready, rd_data_a, rd_data_b);
    end
    idle(); cycle(); sys_rst = 1'b1;
    for (int i = 1; i <= 10; i++) cycle();
    #2 sys_rst = 1'b0; model_reset(); #1;
    cycle(); sys_rst = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      cycle();
      checks++;
      if (ready !== (i == 32)) begin
        errors++; $display("FAIL reset_restart edge %0d: ready=%b, required %b", i, ready, i == 32);
      end
    end
  endtask

  task automatic test_mid_clr();
    clr = 1'b1; cycle(); clr = 1'b0;
    for (int i = 1; i < 20; i++) cycle();
    clr = 1'b1; cycle(); clr = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      cycle();
      checks++;
      if (ready !== (i == 32)) begin
        errors++; $display("FAIL clr_restart edge %0d: ready=%b, required %b", i, ready, i == 32);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      clr      = ($urandom_range(0, 79) == 0);
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_idx   = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      rd_en_a  = ($urandom_range(0, 3) != 0);
      rd_en_b  = ($urandom_range(0, 3) != 0);
      rd_idx_a = 5'($urandom_range(0, 7));
      rd_idx_b = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      cycle();
      checks++;
      if ({rd_data_a, rd_data_b, rd_data_a0, rd_data_b0, ready, ready0} !==
          {e_a1, e_b1, e_a0, e_b0, m_ready, m_ready}) begin
        errors++;
        $display("FAIL random #%0d: a=%h b=%h a0=%h b0=%h rdy=%b/%b, required %h %h %h %h %b",
                 n, rd_data_a, rd_data_b, rd_data_a0, rd_data_b0, ready, ready0,
                 e_a1, e_b1, e_a0, e_b0, m_ready);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_dual_read();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_mid_reset();
    test_mid_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the single-port core register file.
- Two independent read ports and one write port, all usable in the same cycle, so the decode stage can fetch rs1/rs2 and writeback can commit rd together.
- Write-first bypass on each read port.
- Hardware clear sequencer zeroes the array after reset or on request; the block reports when it is usable.
- Register 0 is optionally hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- REG_IDX_WIDTH, 5, index width.
- REG_COUNT, 32, number of registers; must be ≤ 2**REG_IDX_WIDTH and ≥ 2.
- ZERO_REG, 1, 1 = index 0 reads 0 and ignores writes; 0 = index 0 is an ordinary register.

Ports:
- sys_clk  in  1  clock; all state updates on the falling edge.
- sys_rst  in  1  asynchronous, active-low reset.
- clr  in  1  request a full clear sweep; sampled on the falling edge.
- ready  out  1  1 = sweep done; reads and writes are serviced.
- rd_en_a  in  1  read enable, port A.
- rd_idx_a  in  REG_IDX_WIDTH  read index, port A.
- rd_data_a  out  DATA_WIDTH  registered read data, port A.
- rd_en_b  in  1  read enable, port B.
- rd_idx_b  in  REG_IDX_WIDTH  read index, port B.
- rd_data_b  out  DATA_WIDTH  registered read data, port B.
- wr_en  in  1  write enable.
- wr_idx  in  REG_IDX_WIDTH  write index.
- wr_data  in  DATA_WIDTH  write data.

Behaviour:
Reset and edges
- One clock, sys_clk. Reset is asynchronous and active-low on sys_rst.
- All sequential logic updates on the negedge of sys_clk.
- sys_rst low: immediately ready=0, rd_data_a=0, rd_data_b=0, state=CLEAR, sweep counter=0.
- The array itself is not async-reset; the sweep clears it.

State machine: CLEAR, READY
- CLEAR:
  - Each negedge writes 0 to array[counter], then counter += 1.
  - On the edge that writes index REG_COUNT-1: counter returns to 0, state goes to READY, ready goes to 1.
  - The sweep therefore takes exactly REG_COUNT negedges after sys_rst rises.
- READY with clr=1:
  - Next negedge: state=CLEAR, counter=0, ready=0.
  - A wr_en on that same edge is dropped (clr wins).
- CLEAR with clr=1: counter restarts at 0; the sweep begins again.
- While ready=0:
  - wr_en is ignored.
  - Both rd_data outputs are registered to 0 regardless of rd_en.
  - Requesters must hold their requests until ready=1; nothing is queued.

Read ports (READY)
- Latency 1: rd_data_x is updated on the negedge that samples rd_en_x/rd_idx_x.
- rd_en_x=0: rd_data_x <= 0.
- ZERO_REG=1 and rd_idx_x=0: rd_data_x <= 0.
- Bypass: if wr_en=1 and wr_idx==rd_idx_x on the same edge, and the write is not suppressed, rd_data_x <= wr_data (write-first).
- Otherwise rd_data_x <= array[rd_idx_x].
- Ports A and B are fully independent; both may read the same index.
- Index ≥ REG_COUNT: read returns 0.

Write port (READY)
- wr_en=1 writes array[wr_idx] <= wr_data on the negedge.
- Suppressed when ZERO_REG=1 and wr_idx=0, or when wr_idx ≥ REG_COUNT.
- A suppressed write also disables the bypass.

Width rules
- Data passes through unmodified; there is no sign or zero extension.
- The sweep counter is REG_IDX_WIDTH+1 bits wide so that REG_COUNT=2**REG_IDX_WIDTH terminates cleanly.

Test Plan:
- Reset/sweep: default params, release sys_rst -> ready=0 for exactly 32 negedges, rises on the 32nd; all 32 registers then read 0.
- Dual read: write x5=0x1234_5678 and x9=0xDEAD_BEEF; next edge rd_idx_a=5, rd_idx_b=9 -> rd_data_a=0x12345678, rd_data_b=0xDEADBEEF one edge later.
- Bypass: x7 holds 0x11; same edge wr_en=1, wr_idx=7, wr_data=0x22, rd_idx_a=7, rd_en_a=1 -> rd_data_a=0x22; a later read of x7 returns 0x22.
- Zero register: write x0=0xFFFF_FFFF while reading x0 on both ports -> both ports read 0; a later read of x0 returns 0. With ZERO_REG=0 the same stimulus reads back 0xFFFFFFFF.
- Clear request: load x3=0xABCD, pulse clr together with wr_en (x4=0x55) -> write dropped; ready=0 for 32 edges; then x3=0 and x4=0.
- Mid-sweep events: assert sys_rst low at sweep edge 10 -> outputs go to 0 asynchronously and the sweep restarts from 0. Separately, clr at sweep edge 20 -> ready rises 32 edges after that clr.
